config_controller: RTL

CONFIG_CONTROLLER -- requirements
Module: config_controller

---
 rtl/config_controller_pkg.sv | 24 ++
 rtl/config_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_controller_pkg.sv
// rtl/config_controller_pkg.sv - settings record types exported by config_controller
package config_controller_pkg;

  typedef struct packed {
    logic        update;
    logic        mode;
    logic [15:0] update_rate_intensity;
    logic [15:0] update_rate_phase;
    logic [15:0] completion_steps_intensity;
    logic [15:0] completion_steps_phase;
  } silencer_settings_t;

  typedef struct packed {
    logic        update;
    logic [15:0] full_width_start;
  } pulse_width_encoder_settings_t;

  typedef struct packed {
    logic        update;
    logic [31:0] ecat_sync_base_cnt;
    logic [63:0] ecat_sync_time;
  } sync_settings_t;

endpackage

// File: rtl/config_controller.sv
// rtl/config_controller.sv - polls a config BRAM and commits toggled setting groups
//
// Purpose: polls REQ_FLAG (word 0x00), loads every group whose request bit differs
// from the internal ack register into shadow registers, commits them to the
// settings outputs with a one-cycle UPDATE pulse, then writes the new ack word
// to 0x01.
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   BRAM_ADDR/DOUT     word address and read data (BRAM_RD_LATENCY cycles apart)
//   BRAM_WE/DIN        write port, used only for the ACK word
//   SILENCER_SETTINGS  silencer configuration
//   PWE_SETTINGS       pulse-width-encoder configuration
//   SYNC_SETTINGS      EtherCAT sync configuration
module config_controller
  import config_controller_pkg::*;
#(
  parameter int BRAM_RD_LATENCY = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  output logic [7:0]                    BRAM_ADDR,
  input  logic [15:0]                   BRAM_DOUT,
  output logic                          BRAM_WE,
  output logic [15:0]                   BRAM_DIN,
  output silencer_settings_t            SILENCER_SETTINGS,
  output pulse_width_encoder_settings_t PWE_SETTINGS,
  output sync_settings_t                SYNC_SETTINGS
);

  localparam int L      = BRAM_RD_LATENCY;
  localparam int NWORDS = 12;

  typedef enum logic [2:0] {
    IDLE, RD_FLAG, LOAD_SIL, LOAD_PWE, LOAD_SYNC, COMMIT, WR_ACK
  } state_t;

  // Word index space: 0..4 silencer, 5 PWE, 6..11 sync.
  function automatic logic [7:0] idx_addr(input logic [3:0] idx);
    if (idx < 4'd5)       return 8'h10 + {4'd0, idx};
    else if (idx == 4'd5) return 8'h20;
    else                  return 8'h30 + {4'd0, idx - 4'd6};
  endfunction

  function automatic logic [1:0] idx_group(input logic [3:0] idx);
    if (idx < 4'd5)       return 2'd0;
    else if (idx == 4'd5) return 2'd1;
    else                  return 2'd2;
  endfunction

  function automatic state_t group_state(input logic [3:0] idx);
    case (idx_group(idx))
      2'd0:    return LOAD_SIL;
      2'd1:    return LOAD_PWE;
      default: return LOAD_SYNC;
    endcase
  endfunction

  // {valid, idx} of the first word after cur (or the very first when from_start)
  // belonging to a pending group; this is what skips non-pending groups.
  function automatic logic [4:0] next_word(input logic [3:0] cur, input logic from_start,
                                           input logic [2:0] pend);
    logic [4:0] res;
    res = '0;
    for (int i = NWORDS - 1; i >= 0; i--) begin
      if ((from_start || (4'(i) > cur)) && pend[idx_group(4'(i))]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  state_t r_state, w_next;

  logic                r_run_en;
  logic [2:0]          r_ack;
  logic [2:0]          r_pend;
  logic [7:0]          r_cnt;
  logic [7:0]          r_drain;
  logic [3:0]          r_iss_idx;
  logic [L:1]          r_tv;
  logic [3:0]          r_ti [1:L];
  logic [15:0]         r_shadow [0:NWORDS-1];
  logic [7:0]          r_bram_addr;
  logic                r_bram_we;
  logic [15:0]         r_bram_din;
  silencer_settings_t            r_sil;
  pulse_width_encoder_settings_t r_pwe;
  sync_settings_t                r_sync;

  logic       w_load;
  logic       w_iss_vld;
  logic       w_sample;
  logic [2:0] w_flag_pend;
  logic [4:0] w_first;
  logic [4:0] w_nxt;

  assign w_load      = (r_state == LOAD_SIL) || (r_state == LOAD_PWE) || (r_state == LOAD_SYNC);
  // An address is being presented this cycle until the drain countdown starts.
  assign w_iss_vld   = w_load && (r_drain == 8'd0);
  assign w_sample    = (r_state == RD_FLAG) && (r_cnt == 8'(L - 1));
  assign w_flag_pend = BRAM_DOUT[2:0] ^ r_ack;
  assign w_first     = next_word(4'd0, 1'b1, w_flag_pend);
  assign w_nxt       = next_word(r_iss_idx, 1'b0, r_pend);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (r_run_en) w_next = RD_FLAG;
      RD_FLAG: if (w_sample) w_next = w_first[4] ? group_state(w_first[3:0]) : IDLE;
      LOAD_SIL, LOAD_PWE, LOAD_SYNC: begin
        // The state follows the group of the word on the address bus; it holds
        // on the last group while the read pipeline drains.
        if (r_drain == 8'd1)          w_next = COMMIT;
        else if (w_iss_vld && w_nxt[4]) w_next = group_state(w_nxt[3:0]);
      end
      COMMIT:  w_next = WR_ACK;
      WR_ACK:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_run_en    <= 1'b0;
      r_ack       <= '0;
      r_pend      <= '0;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_iss_idx   <= '0;
      r_tv        <= '0;
      for (int k = 1; k <= L; k++) r_ti[k] <= '0;
      for (int i = 0; i < NWORDS; i++) r_shadow[i] <= '0;
      r_bram_addr <= '0;
      r_bram_we   <= 1'b0;
      r_bram_din  <= '0;
      r_sil.update                     <= 1'b0;
      r_sil.mode                       <= 1'b1;
      r_sil.update_rate_intensity      <= 16'd256;
      r_sil.update_rate_phase          <= 16'd256;
      r_sil.completion_steps_intensity <= 16'd10;
      r_sil.completion_steps_phase     <= 16'd40;
      r_pwe.update                     <= 1'b0;
      r_pwe.full_width_start           <= 16'hFF00;
      r_sync.update                    <= 1'b0;
      r_sync.ecat_sync_base_cnt        <= '0;
      r_sync.ecat_sync_time            <= '0;
    end else begin
      // Holds the FSM in IDLE for the first edge after reset release.
      r_run_en <= 1'b1;

      // Tag pipeline: stage k describes the address presented k cycles ago,
      // so stage L lines up with the word currently on BRAM_DOUT.
      r_tv[1] <= w_iss_vld;
      r_ti[1] <= r_iss_idx;
      for (int k = 2; k <= L; k++) begin
        r_tv[k] <= r_tv[k-1];
        r_ti[k] <= r_ti[k-1];
      end
      if (r_tv[L]) r_shadow[r_ti[L]] <= BRAM_DOUT;

      r_sil.update  <= 1'b0;
      r_pwe.update  <= 1'b0;
      r_sync.update <= 1'b0;
      if (r_drain != 8'd0) r_drain <= r_drain - 8'd1;

      case (r_state)
        IDLE: r_cnt <= '0;
        RD_FLAG: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_sample) begin
            // The pass works on this snapshot; later flag changes wait for the next poll.
            r_pend <= w_flag_pend;
            if (w_first[4]) begin
              r_bram_addr <= idx_addr(w_first[3:0]);
              r_iss_idx   <= w_first[3:0];
            end
          end
        end
        LOAD_SIL, LOAD_PWE, LOAD_SYNC: begin
          if (w_iss_vld) begin
            if (w_nxt[4]) begin
              r_bram_addr <= idx_addr(w_nxt[3:0]);
              r_iss_idx   <= w_nxt[3:0];
            end else begin
              r_drain <= 8'(L);
            end
          end
        end
        COMMIT: begin
          if (r_pend[0]) begin
            r_sil.update                     <= 1'b1;
            r_sil.mode                       <= r_shadow[0][0];
            r_sil.update_rate_intensity      <= r_shadow[1];
            r_sil.update_rate_phase          <= r_shadow[2];
            r_sil.completion_steps_intensity <= r_shadow[3];
            r_sil.completion_steps_phase     <= r_shadow[4];
          end
          if (r_pend[1]) begin
            r_pwe.update           <= 1'b1;
            r_pwe.full_width_start <= r_shadow[5];
          end
          if (r_pend[2]) begin
            r_sync.update             <= 1'b1;
            r_sync.ecat_sync_base_cnt <= {r_shadow[7], r_shadow[6]};
            r_sync.ecat_sync_time     <= {r_shadow[11], r_shadow[10], r_shadow[9], r_shadow[8]};
          end
          r_ack       <= r_ack ^ r_pend;
          r_bram_addr <= 8'h01;
          r_bram_we   <= 1'b1;
          r_bram_din  <= {13'd0, r_ack ^ r_pend};
        end
        WR_ACK: begin
          r_bram_addr <= 8'h00;
          r_bram_we   <= 1'b0;
          r_bram_din  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign BRAM_ADDR         = r_bram_addr;
  assign BRAM_WE           = r_bram_we;
  assign BRAM_DIN          = r_bram_din;
  assign SILENCER_SETTINGS = r_sil;
  assign PWE_SETTINGS      = r_pwe;
  assign SYNC_SETTINGS     = r_sync;

endmodule
